// File: rtl/mult_arbiter_if.sv
// Requester, response and multiplier-side signals of mult_arbiter.
// The master modport is the arbiter's view. The slave modport is the system's view.
interface mult_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [15:0]          rsp_data;
   logic                 rsp_err;
   logic                 busy;
   logic                 mult_valid;
   logic [7:0]           mult_a;
   logic [7:0]           mult_b;
   logic                 mult_done;
   logic [15:0]          mult_y;

   modport master (
      input  req_valid, req_a, req_b, mult_done, mult_y,
      output req_ready, rsp_valid, rsp_data, rsp_err, busy,
             mult_valid, mult_a, mult_b
   );

   modport slave (
      output req_valid, req_a, req_b, mult_done, mult_y,
      input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
             mult_valid, mult_a, mult_b
   );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one 8x8 signed multiplier among NUM_REQ requesters.
// Defining MULT_ARB_TIMEOUT_EN adds a WAIT watchdog that produces an error response.
module mult_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic           clk,
   input  logic           rst,
   mult_arbiter_if.master bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      DRAIN
   } state_e;

   state_e       state_q, state_d;
   idx_t         last_grant_q, last_grant_d;
   idx_t         grant_q, grant_d;
   logic [7:0]   mult_a_q, mult_a_d;
   logic [7:0]   mult_b_q, mult_b_d;
   logic [15:0]  prod_q, prod_d;
   logic         err_q, err_d;

   logic               pick_found;
   idx_t               pick_idx;
   idx_t               cand;
   logic [7:0]         pick_a;
   logic [7:0]         pick_b;
   logic [NUM_REQ-1:0] pick_oh;
   logic [NUM_REQ-1:0] grant_oh;

   logic [NUM_REQ-1:0] req_ready_c;
   logic [NUM_REQ-1:0] rsp_valid_c;
   logic               mult_valid_c;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Upward search starting one past the previous winner, wrapping at NUM_REQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = idx_t'((32'(last_grant_q) + i) % NUM_REQ);
         if (!pick_found && bus.req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      pick_a   = '0;
      pick_b   = '0;
      pick_oh  = '0;
      grant_oh = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (idx_t'(j) == pick_idx) begin
            pick_a     = bus.req_a[8*j +: 8];
            pick_b     = bus.req_b[8*j +: 8];
            pick_oh[j] = 1'b1;
         end
         if (idx_t'(j) == grant_q) begin
            grant_oh[j] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      prod_d       = prod_q;
      err_d        = err_q;
      req_ready_c  = '0;
      rsp_valid_c  = '0;
      mult_valid_c = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (rst && pick_found) begin
               req_ready_c  = pick_oh;
               mult_a_d     = pick_a;
               mult_b_d     = pick_b;
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               err_d        = 1'b0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            mult_valid_c = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_d        = '0;
`endif
            state_d      = WAIT;
         end
         WAIT: begin
            if (bus.mult_done) begin
               prod_d  = bus.mult_y;
               err_d   = 1'b0;
               state_d = RESP;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RESP: begin
            rsp_valid_c = grant_oh;
`ifdef MULT_ARB_TIMEOUT_EN
            // A timed-out multiplier never raised done, so there is nothing to drain.
            state_d     = err_q ? IDLE : DRAIN;
`else
            state_d     = DRAIN;
`endif
         end
         DRAIN: begin
            if (!bus.mult_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= idx_t'(NUM_REQ - 1);
         grant_q      <= '0;
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         prod_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         prod_q       <= prod_d;
         err_q        <= err_d;
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.rsp_err = (state_q == RESP) && err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_c;
   assign bus.rsp_data   = (state_q == RESP) ? prod_q : '0;
   assign bus.busy       = (state_q != IDLE);
   assign bus.mult_valid = mult_valid_c;
   assign bus.mult_a     = mult_a_q;
   assign bus.mult_b     = mult_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier of adjustable latency and done width.
module tb_mult_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mult_arbiter_if #(.NUM_REQ(4)) bus ();

   mult_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Multiplier model: done rises m_lat cycles after the start strobe and stays high m_hold cycles.
   int m_lat   = 2;
   int m_hold  = 1;
   bit m_never = 1'b0;
   bit m_pend;
   int m_cnt;
   int m_hcnt;

   always @(posedge clk) begin
      if (!rst) begin
         bus.mult_done <= 1'b0;
         bus.mult_y    <= '0;
         m_pend        <= 1'b0;
         m_cnt         <= 0;
         m_hcnt        <= 0;
      end else if (bus.mult_valid) begin
         m_pend     <= 1'b1;
         m_cnt      <= m_lat;
         bus.mult_y <= $signed(bus.mult_a) * $signed(bus.mult_b);
      end else if (m_pend) begin
         if (!m_never) begin
            if (m_cnt <= 1) begin
               m_pend        <= 1'b0;
               bus.mult_done <= 1'b1;
               m_hcnt        <= m_hold;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end else if (bus.mult_done) begin
         if (m_hcnt <= 1) bus.mult_done <= 1'b0;
         else             m_hcnt        <= m_hcnt - 1;
      end
   end

   // Event log, sampled mid-cycle.
   int          cyc = 0;
   int          g_idx[$];
   int          g_cyc[$];
   int          r_idx[$];
   int          r_cyc[$];
   logic [15:0] r_dat[$];
   logic        r_err[$];
   int          mv_cyc[$];
   int          d_rise[$];
   int          viol = 0;
   bit          pend_drain = 1'b0;
   bit          prev_mv = 1'b0;
   bit          prev_done = 1'b0;
   logic [3:0]  rdy_seen = '0;
   bit          hold_all = 1'b0;

   function automatic int oh2i(logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      cyc++;
      rdy_seen = bus.req_ready;
      if (rst) begin
         if (bus.req_ready != '0) begin
            g_idx.push_back(oh2i(bus.req_ready));
            g_cyc.push_back(cyc);
         end
         if (bus.rsp_valid != '0) begin
            r_idx.push_back(oh2i(bus.rsp_valid));
            r_cyc.push_back(cyc);
            r_dat.push_back(bus.rsp_data);
            r_err.push_back(bus.rsp_err);
         end
         if (bus.mult_valid) mv_cyc.push_back(cyc);
         if (bus.mult_done && !prev_done) d_rise.push_back(cyc);
         if (!$onehot0(bus.req_ready) || !$onehot0(bus.rsp_valid) ||
             (bus.req_ready != '0 && bus.rsp_valid != '0)) viol++;
         // A new start while an old done has not yet fallen, or a start wider than one cycle.
         if (bus.mult_valid && (pend_drain || prev_mv)) viol++;
         if (bus.rsp_valid != '0)  pend_drain = 1'b1;
         else if (!bus.mult_done)  pend_drain = 1'b0;
      end else begin
         pend_drain = 1'b0;
      end
      prev_mv   = bus.mult_valid;
      prev_done = bus.mult_done;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!hold_all) bus.req_valid = bus.req_valid & ~rdy_seen;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[8*i +: 8] = a;
      bus.req_b[8*i +: 8] = b;
      bus.req_valid[i]    = 1'b1;
   endtask

   task automatic wait_rsp(input int n, input int budget, input string tag);
      int k = 0;
      while (r_idx.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(r_idx.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (bus.busy && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(bus.busy), 32'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   int   exp_g[6] = '{0, 1, 2, 3, 0, 1};
   logic [15:0] exp_d[6] = '{16'h0006, 16'hFFDD, 16'h2710, 16'h0001, 16'h0006, 16'hFFDD};
   int   nrsp;
   int   k;
   int   gc;

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_hs",   32'({bus.req_ready, bus.rsp_valid}), 32'd0);
      chk("rst_rsp",  32'({bus.rsp_err, bus.rsp_data}), 32'd0);
      chk("rst_mult", 32'({bus.busy, bus.mult_valid, bus.mult_a, bus.mult_b}), 32'd0);
      rst = 1'b1;
      tick();

      // Single request: 3 * -4
      set_req(0, 8'd3, 8'hFC);
      wait_rsp(1, 40, "t1_wait");
      wait_idle(40, "t1_idle");
      chk("t1_grant", 32'(g_idx[0]), 32'd0);
      chk("t1_idx",   32'(r_idx[0]), 32'd0);
      chk("t1_data",  32'(r_dat[0]), 32'h0000FFF4);
      chk("t1_err",   32'(r_err[0]), 32'd0);
      chk("t1_mv_n",  32'(mv_cyc.size()), 32'd1);
      chk("t1_mv_lat", 32'(mv_cyc[0] - g_cyc[0]), 32'd1);
      chk("t1_rsp_lat", 32'(r_cyc[0] - d_rise[0]), 32'd1);
      chk("t1_opnd_hold", 32'({bus.mult_a, bus.mult_b}), 32'h000003FC);

      // Operand extremes
      set_req(2, 8'h80, 8'h80);
      wait_rsp(2, 40, "t2a_wait");
      wait_idle(40, "t2a_idle");
      chk("t2a_idx",  32'(r_idx[1]), 32'd2);
      chk("t2a_data", 32'(r_dat[1]), 32'h00004000);
      set_req(3, 8'h7F, 8'h80);
      wait_rsp(3, 40, "t2b_wait");
      wait_idle(40, "t2b_idle");
      chk("t2b_idx",  32'(r_idx[2]), 32'd3);
      chk("t2b_data", 32'(r_dat[2]), 32'h0000C080);

      // Two simultaneous requesters, done held 5 cycles
      pulse_rst();
      m_hold = 5;
      set_req(0, 8'd3, 8'd5);
      set_req(1, 8'hF9, 8'd9);
      wait_rsp(5, 120, "t3_wait");
      wait_idle(40, "t3_idle");
      repeat (3) tick();
      chk("t3_g0",   32'(g_idx[3]), 32'd0);
      chk("t3_g1",   32'(g_idx[4]), 32'd1);
      chk("t3_d0",   32'(r_dat[3]), 32'h0000000F);
      chk("t3_d1",   32'(r_dat[4]), 32'h0000FFC1);
      chk("t3_i1",   32'(r_idx[4]), 32'd1);
      chk("t3_rsp_n", 32'(r_idx.size()), 32'd5);
      chk("t3_proto", 32'(viol), 32'd0);

      // All four held continuously for six transactions
      pulse_rst();
      m_hold   = 2;
      hold_all = 1'b1;
      set_req(0, 8'd2,   8'd3);
      set_req(1, 8'hFB,  8'd7);
      set_req(2, 8'd100, 8'd100);
      set_req(3, 8'hFF,  8'hFF);
      wait_rsp(11, 300, "t4_wait");
      bus.req_valid = '0;
      hold_all      = 1'b0;
      wait_idle(40, "t4_idle");
      chk("t4_grant_n", 32'(g_idx.size()), 32'd11);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t4_grant%0d", i), 32'(g_idx[5+i]), 32'(exp_g[i]));
         chk($sformatf("t4_idx%0d", i),   32'(r_idx[5+i]), 32'(exp_g[i]));
         chk($sformatf("t4_data%0d", i),  32'(r_dat[5+i]), 32'(exp_d[i]));
      end

      // Reset while waiting on the multiplier
      m_hold = 1;
      m_lat  = 10;
      set_req(1, 8'd5, 8'd5);
      k = 0;
      while (g_idx.size() < 12 && k < 20) begin
         tick();
         k++;
      end
      chk("t5_granted", 32'(g_idx.size()), 32'd12);
      repeat (2) tick();
      nrsp = r_idx.size();
      pulse_rst();
      @(negedge clk);
      chk("t5_hs",   32'({bus.req_ready, bus.rsp_valid}), 32'd0);
      chk("t5_rsp",  32'({bus.rsp_err, bus.rsp_data}), 32'd0);
      chk("t5_mult", 32'({bus.busy, bus.mult_valid, bus.mult_a, bus.mult_b}), 32'd0);
      repeat (20) tick();
      chk("t5_no_rsp", 32'(r_idx.size()), 32'(nrsp));
      m_lat = 2;
      set_req(0, 8'hFE, 8'hFD);
      set_req(1, 8'd1,  8'd1);
      set_req(2, 8'd1,  8'd1);
      set_req(3, 8'd1,  8'd1);
      wait_rsp(15, 200, "t5_wait");
      wait_idle(40, "t5_idle");
      chk("t5_first_grant", 32'(g_idx[12]), 32'd0);
      chk("t5_first_data",  32'(r_dat[11]), 32'h00000006);

      // Multiplier that does not answer
      m_never = 1'b1;
      set_req(2, 8'd4, 8'd4);
`ifdef MULT_ARB_TIMEOUT_EN
      k = 0;
      while (g_idx.size() < 17 && k < 20) begin
         tick();
         k++;
      end
      chk("t6_granted", 32'(g_idx.size()), 32'd17);
      gc = g_cyc[16];
      wait_rsp(16, 100, "t6_wait");
      chk("t6_lat",  32'(r_cyc[15] - gc), 32'd66);
      chk("t6_err",  32'(r_err[15]), 32'd1);
      chk("t6_data", 32'(r_dat[15]), 32'd0);
      chk("t6_idx",  32'(r_idx[15]), 32'd2);
      @(negedge clk);
      chk("t6_idle", 32'(bus.busy), 32'd0);
      m_never = 1'b0;
      repeat (10) tick();
      chk("t6_stale_done", 32'(r_idx.size()), 32'd16);
`else
      repeat (100) tick();
      chk("t6_no_rsp", 32'(r_idx.size()), 32'd15);
      chk("t6_busy",   32'(bus.busy), 32'd1);
      m_never = 1'b0;
      wait_rsp(16, 20, "t6_wait");
      chk("t6_data", 32'(r_dat[15]), 32'h00000010);
      chk("t6_err",  32'(r_err[15]), 32'd0);
      chk("t6_idx",  32'(r_idx[15]), 32'd2);
      wait_idle(40, "t6_idle");
`endif

      chk("proto_viol", 32'(viol), 32'd0);
      chk("mv_per_grant", 32'(mv_cyc.size()), 32'(g_idx.size()));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
